// File: rtl/led_cube_pkg.sv
// Shared definitions for the LED cube UART scheduler.
//   sched_state_t   : scheduler FSM states
//   *_BIT           : UART status register bit positions
//   *_ADDR_DEF      : default Avalon word addresses of the UART registers
//   cnt_width()     : width of a counter that must hold 0..maxval (min 1 bit)
package led_cube_pkg;

    typedef enum logic [2:0] {
        S_GAP,
        S_POLL_REQ,
        S_POLL_WAIT,
        S_DECIDE,
        S_RX_REQ,
        S_RX_WAIT,
        S_TX_REQ
    } sched_state_t;

    localparam int unsigned RRDY_BIT = 7;
    localparam int unsigned TRDY_BIT = 6;
    localparam int unsigned TMT_BIT  = 5;

    localparam logic [4:0] STATUS_ADDR_DEF = 5'h08;
    localparam logic [4:0] RXDATA_ADDR_DEF = 5'h00;
    localparam logic [4:0] TXDATA_ADDR_DEF = 5'h04;

    function automatic int unsigned cnt_width(input int unsigned maxval);
        return (maxval > 0) ? $clog2(maxval + 1) : 1;
    endfunction

endpackage

// File: rtl/led_cube_uart_watchdog.sv
// Transaction watchdog for the UART scheduler (used only when
// LED_CUBE_UART_SCHED_TIMEOUT_EN is defined).
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : return the count to zero
//   i_enable     : count this cycle
//   o_expire     : high in the LIMIT-th enabled cycle since the last clear
module led_cube_uart_watchdog
    import led_cube_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = cnt_width(LIMIT);

    logic [CW-1:0] r_cnt;

    assign o_expire = i_enable && (r_cnt == CW'(LIMIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_cube_uart_scheduler.sv
// Avalon-MM master sequencer for the LED cube UART: polls the status
// register, then reads rxdata (RRDY) or writes txdata (TRDY + tx_valid),
// arbitrating round-robin when both are possible.
// Optional feature macro: LED_CUBE_UART_SCHED_TIMEOUT_EN (transaction
// watchdog driving sched_err); without it sched_err is constant 0.
// Ports:
//   clock_sink_clk / reset_sink_reset : clock, synchronous active-high reset
//   avalon_master_*                   : Avalon-MM master toward the UART slave
//   tx_valid / tx_data / tx_ready     : upstream byte requester (tx_ready pulses)
//   rx_valid / rx_data                : received byte toward the cube driver
//   uart_status                       : last status word read
//   sched_err                         : sticky watchdog error
module led_cube_uart_scheduler
    import led_cube_pkg::*;
#(
    parameter logic [4:0]  STATUS_ADDR = STATUS_ADDR_DEF,
    parameter logic [4:0]  RXDATA_ADDR = RXDATA_ADDR_DEF,
    parameter logic [4:0]  TXDATA_ADDR = TXDATA_ADDR_DEF,
    parameter int unsigned POLL_GAP    = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic        clock_sink_clk,
    input  logic        reset_sink_reset,
    output logic [4:0]  avalon_master_address,
    output logic        avalon_master_read,
    output logic        avalon_master_write,
    output logic [15:0] avalon_master_writedata,
    input  logic [15:0] avalon_master_readdata,
    input  logic        avalon_master_readdatavalid,
    input  logic        avalon_master_waitrequest,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [15:0] uart_status,
    output logic        sched_err
);

    localparam int unsigned   GW       = cnt_width(POLL_GAP);
    localparam logic [GW-1:0] GAP_LOAD = (POLL_GAP > 0) ? GW'(POLL_GAP - 1) : '0;
    // With no gap the loop skips GAP entirely to keep the period at POLL_GAP + 3.
    localparam sched_state_t  GAP_EXIT = (POLL_GAP > 0) ? S_GAP : S_POLL_REQ;

    sched_state_t r_state;
    sched_state_t w_next;
    logic [GW-1:0] r_gap_cnt;
    logic [15:0]   r_status;
    logic [15:0]   r_wdata;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_tx_ready;
    logic          r_last_tx;
    logic          w_rrdy;
    logic          w_tx_ok;
    logic          w_grant_rx;
    logic          w_grant_tx;
    logic          w_expire;

    assign w_rrdy  = r_status[RRDY_BIT];
    assign w_tx_ok = r_status[TRDY_BIT] & tx_valid;
    // On a tie the side not granted last wins; r_last_tx resets to 1 so RX wins first.
    assign w_grant_rx = w_rrdy  & (!w_tx_ok | r_last_tx);
    assign w_grant_tx = w_tx_ok & (!w_rrdy  | !r_last_tx);

`ifdef LED_CUBE_UART_SCHED_TIMEOUT_EN
    logic w_wd_en;
    logic r_err;

    assign w_wd_en = (r_state == S_POLL_REQ) || (r_state == S_POLL_WAIT) ||
                     (r_state == S_RX_REQ)   || (r_state == S_RX_WAIT)   ||
                     (r_state == S_TX_REQ);

    // Count spans a whole REQ+WAIT transaction; cleared in GAP/DECIDE.
    led_cube_uart_watchdog #(
        .LIMIT(TIMEOUT)
    ) u_watchdog (
        .i_clk    (clock_sink_clk),
        .i_rst    (reset_sink_reset),
        .i_clear  (!w_wd_en),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            r_err <= 1'b0;
        end else if (w_expire) begin
            r_err <= 1'b1;
        end
    end

    assign sched_err = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_expire  = 1'b0;
    assign sched_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            r_state <= S_GAP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_GAP:       if (r_gap_cnt == '0) w_next = S_POLL_REQ;
            S_POLL_REQ:  if (!avalon_master_waitrequest) w_next = S_POLL_WAIT;
            S_POLL_WAIT: if (avalon_master_readdatavalid) w_next = S_DECIDE;
            S_DECIDE: begin
                if (w_grant_rx)      w_next = S_RX_REQ;
                else if (w_grant_tx) w_next = S_TX_REQ;
                else                 w_next = GAP_EXIT;
            end
            S_RX_REQ:    if (!avalon_master_waitrequest) w_next = S_RX_WAIT;
            S_RX_WAIT:   if (avalon_master_readdatavalid) w_next = GAP_EXIT;
            S_TX_REQ:    if (!avalon_master_waitrequest) w_next = GAP_EXIT;
            default:     w_next = S_GAP;
        endcase
        if (w_expire) begin
            w_next = S_GAP;
        end
    end

    // Avalon command outputs, decoded from the registered state
    always_comb begin
        avalon_master_read    = 1'b0;
        avalon_master_write   = 1'b0;
        avalon_master_address = STATUS_ADDR;
        case (r_state)
            S_POLL_REQ: avalon_master_read = 1'b1;
            S_RX_REQ: begin
                avalon_master_read    = 1'b1;
                avalon_master_address = RXDATA_ADDR;
            end
            S_TX_REQ: begin
                avalon_master_write   = 1'b1;
                avalon_master_address = TXDATA_ADDR;
            end
            default: ;
        endcase
    end

    // Gap counter, arbitration pointer and data registers
    always_ff @(posedge clock_sink_clk) begin
        if (reset_sink_reset) begin
            r_gap_cnt  <= '0;
            r_status   <= '0;
            r_wdata    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_last_tx  <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;

            if (w_next == S_GAP && r_state != S_GAP) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (r_state == S_POLL_WAIT && avalon_master_readdatavalid && !w_expire) begin
                r_status <= avalon_master_readdata;
            end

            if (r_state == S_DECIDE) begin
                if (w_grant_rx) begin
                    r_last_tx <= 1'b0;
                end else if (w_grant_tx) begin
                    r_last_tx <= 1'b1;
                    r_wdata   <= {8'h00, tx_data};
                end
            end

            if (r_state == S_RX_WAIT && avalon_master_readdatavalid && !w_expire) begin
                r_rx_data  <= avalon_master_readdata[7:0];
                r_rx_valid <= 1'b1;
            end

            if (r_state == S_TX_REQ && !avalon_master_waitrequest && !w_expire) begin
                r_tx_ready <= 1'b1;
            end
        end
    end

    assign avalon_master_writedata = r_wdata;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_ready    = r_tx_ready;
    assign uart_status = r_status;

endmodule

// File: tb/tb_led_cube_uart_scheduler.sv
// Self-checking bench for led_cube_uart_scheduler: the bench plays the UART
// slave transaction by transaction and predicts grants, idle gaps and
// handshake pulses from a transaction-level model.
module tb_led_cube_uart_scheduler;

    localparam int unsigned PG = 4;
    localparam logic [4:0] A_STATUS = 5'h08;
    localparam logic [4:0] A_RX     = 5'h00;
    localparam logic [4:0] A_TX     = 5'h04;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  address;
    logic        rd, wr;
    logic [15:0] writedata;
    logic [15:0] readdata = '0;
    logic        rdv = 1'b0;
    logic        waitreq = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_ready, rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] uart_status;
    logic        sched_err;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model state
    int   exp_idle;
    logic exp_last_tx;
    int   last_obs;

    always #5 clk = ~clk;

    led_cube_uart_scheduler #(
        .STATUS_ADDR (A_STATUS),
        .RXDATA_ADDR (A_RX),
        .TXDATA_ADDR (A_TX),
        .POLL_GAP    (PG),
        .TIMEOUT     (16)
    ) dut (
        .clock_sink_clk              (clk),
        .reset_sink_reset            (rst),
        .avalon_master_address       (address),
        .avalon_master_read          (rd),
        .avalon_master_write         (wr),
        .avalon_master_writedata     (writedata),
        .avalon_master_readdata      (readdata),
        .avalon_master_readdatavalid (rdv),
        .avalon_master_waitrequest   (waitreq),
        .tx_valid                    (tx_valid),
        .tx_data                     (tx_data),
        .tx_ready                    (tx_ready),
        .rx_valid                    (rx_valid),
        .rx_data                     (rx_data),
        .uart_status                 (uart_status),
        .sched_err                   (sched_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Count idle cycles (no command) until the next command, bounded.
    task automatic wait_cmd(output int idle);
        logic spur;
        spur = 1'b0;
        idle = 0;
        while (!rd && !wr && idle < 100) begin
            if (tx_ready || rx_valid) spur = 1'b1;
            idle++;
            @(negedge clk);
        end
        check("spurious_pulse", 32'(spur), 0);
        check("rd_wr_exclusive", 32'(rd && wr), 0);
    endtask

    task automatic read_xfer(input string tag, input logic [4:0] addr, input int nw,
                             input logic [15:0] resp);
        logic [4:0] a0;
        logic       stable;
        check({tag, "_rdcmd"}, {30'd0, rd, wr}, 32'b10);
        check({tag, "_addr"}, 32'(address), 32'(addr));
        a0 = address;
        stable = 1'b1;
        for (int k = 0; k < nw; k++) begin
            waitreq = 1'b1;
            @(negedge clk);
            if (!rd || wr || address != a0) stable = 1'b0;
        end
        if (nw > 0) check({tag, "_stall_stable"}, 32'(stable), 1);
        waitreq = 1'b0;
        @(negedge clk);
        check({tag, "_rd_drop"}, 32'(rd), 0);
        rdv = 1'b1;
        readdata = resp;
        @(negedge clk);
        rdv = 1'b0;
        readdata = 16'($urandom);
    endtask

    task automatic write_xfer(input int nw, input logic [15:0] exp_wd, input logic drop);
        logic stable;
        check("tx_wrcmd", {30'd0, rd, wr}, 32'b01);
        check("tx_addr", 32'(address), 32'(A_TX));
        check("tx_wdata", 32'(writedata), 32'(exp_wd));
        if (drop) begin
            tx_valid = 1'b0;
            tx_data  = 8'($urandom);
        end
        stable = 1'b1;
        for (int k = 0; k < nw; k++) begin
            waitreq = 1'b1;
            @(negedge clk);
            if (!wr || rd || address != A_TX || writedata != exp_wd) stable = 1'b0;
        end
        if (nw > 0) check("tx_stall_stable", 32'(stable), 1);
        waitreq = 1'b0;
        @(negedge clk);
        check("tx_wr_drop", 32'(wr), 0);
        check("tx_ready_pulse", 32'(tx_ready), 1);
        @(negedge clk);
        check("tx_ready_single", 32'(tx_ready), 0);
    endtask

    // One poll plus whatever transaction the status/tx request implies.
    task automatic run_iter(input logic [15:0] st, input logic txv, input logic [7:0] txd,
                            input int pw, input int xw, input logic [7:0] rxb,
                            input logic drop);
        int idle;
        int exp_kind;
        int obs_kind;
        logic rrdy, txok;
        tx_valid = txv;
        tx_data  = txd;
        wait_cmd(idle);
        check("poll_idle", 32'(idle), 32'(exp_idle));
        read_xfer("poll", A_STATUS, pw, st);
        check("uart_status", 32'(uart_status), 32'(st));

        rrdy = st[7];
        txok = st[6] && txv;
        if (rrdy && txok) exp_kind = exp_last_tx ? 1 : 2;
        else if (rrdy)    exp_kind = 1;
        else if (txok)    exp_kind = 2;
        else              exp_kind = 0;

        wait_cmd(idle);
        if (rd && address == A_RX)           obs_kind = 1;
        else if (wr && address == A_TX)      obs_kind = 2;
        else if (rd && address == A_STATUS)  obs_kind = 0;
        else                                 obs_kind = 3;
        check("grant", 32'(obs_kind), 32'(exp_kind));
        last_obs = obs_kind;

        case (exp_kind)
            1: begin
                check("decide_idle", 32'(idle), 1);
                read_xfer("rx", A_RX, xw, {8'($urandom), rxb});
                check("rx_valid_pulse", 32'(rx_valid), 1);
                check("rx_data", 32'(rx_data), 32'(rxb));
                @(negedge clk);
                check("rx_valid_single", 32'(rx_valid), 0);
                exp_last_tx = 1'b0;
                exp_idle    = PG - 1;
            end
            2: begin
                check("decide_idle", 32'(idle), 1);
                write_xfer(xw, {8'h00, txd}, drop);
                tx_valid    = 1'b0;
                exp_last_tx = 1'b1;
                exp_idle    = PG - 1;
            end
            default: begin
                check("gap_idle", 32'(idle), 32'(PG + 1));
                exp_idle = 0;
            end
        endcase
    endtask

    initial begin
        int idle;
        int pat [4];
        pat = '{1, 2, 1, 2};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_read",    32'(rd), 0);
        check("rst_write",   32'(wr), 0);
        check("rst_addr",    32'(address), 32'(A_STATUS));
        check("rst_wdata",   32'(writedata), 0);
        check("rst_txready", 32'(tx_ready), 0);
        check("rst_rxvalid", 32'(rx_valid), 0);
        check("rst_rxdata",  32'(rx_data), 0);
        check("rst_status",  32'(uart_status), 0);
        check("rst_err",     32'(sched_err), 0);
        rst = 1'b0;
        exp_idle    = 1;
        exp_last_tx = 1'b1;

        // Directed: receive, transmit, alternation, long stall on TX
        run_iter(16'h0080, 1'b0, 8'h00, 0, 0, 8'h41, 1'b0);
        run_iter(16'h0040, 1'b1, 8'h5A, 0, 0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_iter(16'h00C0, 1'b1, 8'(8'h10 + i), 0, 0, 8'(8'h20 + i), 1'b0);
            check("alternate", 32'(last_obs), 32'(pat[i]));
        end
        run_iter(16'h0040, 1'b1, 8'hA7, 1, 5, 8'h00, 1'b1);

        // Reset while waiting for rxdata, then a late response
        tx_valid = 1'b0;
        wait_cmd(idle);
        check("poll_idle", 32'(idle), 32'(exp_idle));
        read_xfer("poll", A_STATUS, 0, 16'h0080);
        wait_cmd(idle);
        check("rxreq_addr", 32'(address), 32'(A_RX));
        waitreq = 1'b0;
        @(negedge clk);
        check("rxwait_rd", 32'(rd), 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rd", 32'(rd), 0);
        check("midrst_wdata", 32'(writedata), 0);
        check("midrst_status", 32'(uart_status), 0);
        rst = 1'b0;
        rdv = 1'b1;
        readdata = 16'h0033;
        @(negedge clk);
        rdv = 1'b0;
        check("late_rx_valid", 32'(rx_valid), 0);
        check("late_rx_data", 32'(rx_data), 0);
        check("repoll", {27'd0, rd, address}, {27'd0, 1'b1, A_STATUS});
        exp_idle    = 0;
        exp_last_tx = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            run_iter(16'($urandom), 1'($urandom), 8'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     8'($urandom), 1'($urandom));
        end

`ifdef LED_CUBE_UART_SCHED_TIMEOUT_EN
        begin
            int n;
            tx_valid = 1'b0;
            wait_cmd(idle);
            check("wd_poll_idle", 32'(idle), 32'(exp_idle));
            check("wd_poll_addr", 32'(address), 32'(A_STATUS));
            waitreq = 1'b1;
            n = 0;
            while (rd && n < 100) begin
                n++;
                @(negedge clk);
            end
            waitreq = 1'b0;
            check("wd_cycles", 32'(n), 16);
            check("wd_err", 32'(sched_err), 1);
            wait_cmd(idle);
            check("wd_gap", 32'(idle), 32'(PG));
            read_xfer("wd_repoll", A_STATUS, 0, 16'h0000);
            check("wd_err_sticky", 32'(sched_err), 1);
        end
`else
        check("err_tied", 32'(sched_err), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
